cp_prefetch_buffer: RTL and testbench

Instruction prefetch unit between the instruction memory port and `cp_if_stage`. It issues sequential word fetches ahead of demand and keeps up to two requests in flight. Returned words go into a small in-order FIFO, and the IF stage pops entries with a valid/ready handshake. A redirect (branch, jump, trap) flushes the buffered words and any responses still outstanding, then restarts fetching at the new address.

---
 rtl/cp_pkg.sv | 17 +
 rtl/cp_prefetch_buffer_fifo.sv | 70 +++++++
 rtl/cp_prefetch_buffer.sv | 151 +++++++++++++++
 tb/tb_cp_prefetch_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types for the instruction prefetch buffer: the fetch FSM states,
// the FIFO entry layout and the instruction word size in bytes.
package cp_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/cp_prefetch_buffer_fifo.sv
// In-order instruction FIFO with same-cycle push/pop (also when full) and a
// flush that empties it in one edge. The head reads as zero while empty.
module cp_fetch_fifo
    import cp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fifo_entry_t            push_data_i,
    input  logic                   pop_i,
    output fifo_entry_t            head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop frees the head slot in the same edge, so a push into a full FIFO is fine.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: the storage array has no reset; only pointers and count are reset,
    // and the head is forced to zero while empty so stale words never leak out.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cp_prefetch_buffer.sv
// Instruction prefetch unit: issues sequential word fetches ahead of demand,
// buffers the returned words in order and flushes everything on a redirect.
module cp_prefetch_buffer
    import cp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_raddr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_addr_q;
    logic [31:0]      resp_addr_q;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] discard_q, discard_d;

    logic             issue;
    logic             rvalid_ok;
    logic             drop_word;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_addr;
    logic [31:0]      boot_addr;

    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign redirect_addr = redirect_addr_i & ~32'h3;
    assign boot_addr     = boot_addr_i & ~32'h3;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rvalid_ok  = instr_rvalid_i && (outstanding_q != '0);
    assign drop_word  = rvalid_ok && (discard_q != '0);
    assign push       = rvalid_ok && !drop_word && !redirect_i;
    assign pop        = !fifo_empty && ready_i && !redirect_i;
    assign push_entry = '{instr: instr_rdata_i, pc: resp_addr_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case (state_q)
            BOOT: state_d = RUN;
            RUN:  state_d = RUN;
        endcase

        // Admission reserves a FIFO slot for every in-flight response.
        if (state_q == RUN && fetch_en_i && !redirect_i
            && (32'(outstanding_q) < MAX_OUT)
            && ((32'(fifo_count) + 32'(outstanding_q)) < DEPTH)) begin
            issue = 1'b1;
        end

        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(rvalid_ok);

        if (redirect_i) begin
            discard_d = outstanding_d;
        end else if (drop_word) begin
            discard_d = discard_q - OUT_W'(1);
        end
    end

    // A redirect wins over the boot address and over normal advancing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
        end else if (redirect_i) begin
            fetch_addr_q <= redirect_addr;
            resp_addr_q  <= redirect_addr;
        end else if (state_q == BOOT) begin
            fetch_addr_q <= boot_addr;
            resp_addr_q  <= boot_addr;
        end else begin
            if (issue) begin
                fetch_addr_q <= fetch_addr_q + 32'(INSTR_BYTES);
            end
            if (push) begin
                resp_addr_q <= resp_addr_q + 32'(INSTR_BYTES);
            end
        end
    end

    cp_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign instr_req_o   = issue;
    assign instr_raddr_o = fetch_addr_q;
    assign valid_o       = !fifo_empty;
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;
    assign busy_o        = (outstanding_q != '0) || !fifo_empty;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_i && outstanding_q == '0))
        else $warning("cp_prefetch_buffer: rvalid with no request outstanding, ignored");

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full && !pop))
        else $error("cp_prefetch_buffer: push into full FIFO without a slot");

endmodule

// File: tb/tb_cp_prefetch_buffer.sv
// Scoreboard bench for cp_prefetch_buffer: a fixed-latency memory model answers
// requests, and every popped word is compared against the expected fetch stream.
module tb_cp_prefetch_buffer;
    import cp_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] boot_addr_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_raddr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        busy_o;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_rsp_t;

    mem_rsp_t    mem_q[$];
    fifo_entry_t sb_q[$];
    logic [31:0] exp_addr;
    int          cyc;
    int          lat;
    int          n_vec;
    int          n_err;
    int          n_req;
    int          n_pop;
    bit          spurious;

    logic        obs_req;
    logic        obs_valid;
    logic        obs_busy;
    logic [31:0] obs_addr;
    logic [31:0] obs_pc;

    cp_prefetch_buffer #(
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .boot_addr_i     (boot_addr_i),
        .fetch_en_i      (fetch_en_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_req_o     (instr_req_o),
        .instr_raddr_o   (instr_raddr_o),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .busy_o          (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   32'(instr_req_o), 32'd0);
        check({tag, "_raddr"}, instr_raddr_o,    32'd0);
        check({tag, "_valid"}, 32'(valid_o),     32'd0);
        check({tag, "_instr"}, instr_o,          32'd0);
        check({tag, "_pc"},    pc_o,             32'd0);
        check({tag, "_busy"},  32'(busy_o),      32'd0);
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic run_cycle();
        cyc++;
        if (spurious) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = 32'hDEAD_BEEF;
            spurious       = 1'b0;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
        #2;
        obs_req   = instr_req_o;
        obs_addr  = instr_raddr_o;
        obs_valid = valid_o;
        obs_busy  = busy_o;
        obs_pc    = pc_o;
        if (redirect_i) begin
            check("no_req_on_redirect", 32'(instr_req_o), 32'd0);
            sb_q.delete();
            exp_addr = redirect_addr_i & ~32'h3;
            n_req    = 0;
            n_pop    = 0;
        end else if (instr_req_o) begin
            check("req_addr", instr_raddr_o, exp_addr);
            mem_q.push_back('{due: cyc + lat, data: word_of(instr_raddr_o)});
            sb_q.push_back('{instr: word_of(exp_addr), pc: exp_addr});
            exp_addr += 32'd4;
            n_req++;
        end
        if (valid_o && ready_i && !redirect_i) begin
            if (sb_q.size() == 0) begin
                check("pop_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                check("pop_pc",    pc_o,    sb_q[0].pc);
                check("pop_instr", instr_o, sb_q[0].instr);
                void'(sb_q.pop_front());
            end
            n_pop++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_ni          = 1'b0;
        fetch_en_i      = 1'b0;
        ready_i         = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        instr_rvalid_i  = 1'b0;
        instr_rdata_i   = '0;
        spurious        = 1'b0;
        boot_addr_i     = boot;
        sb_q.delete();
        mem_q.delete();
        exp_addr = boot & ~32'h3;
        n_req    = 0;
        n_pop    = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        rst_ni = 1'b1;
    endtask

    task automatic drain(input string tag);
        fetch_en_i = 1'b0;
        ready_i    = 1'b1;
        repeat (8) run_cycle();
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_idle"},     32'(obs_busy),    32'd0);
        check({tag, "_pops"},     32'(n_pop),       32'(n_req));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        lat   = 1;

        // Boot and streaming with 1-cycle memory.
        do_reset(32'h0000_0080);
        lat = 1; fetch_en_i = 1'b1; ready_i = 1'b1;
        run_cycle();
        check("boot_no_req", 32'(obs_req), 32'd0);
        run_cycle();
        check("first_req",  32'(obs_req), 32'd1);
        check("first_addr", obs_addr,      32'h0000_0080);
        run_cycle();
        check("second_req",   32'(obs_req),   32'd1);
        check("no_valid_yet", 32'(obs_valid), 32'd0);
        run_cycle();
        check("first_valid", 32'(obs_valid), 32'd1);
        check("first_pc",    obs_pc,         32'h0000_0080);
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            check("no_bubble",  32'(obs_valid), 32'd1);
            check("stream_req", 32'(obs_req),   32'd1);
        end
        drain("boot");

        // Backpressure: four words buffer up, then drain in order.
        do_reset(32'h0000_0200);
        lat = 1; fetch_en_i = 1'b1; ready_i = 1'b0;
        repeat (10) run_cycle();
        check("bp_reqs",    32'(n_req),     32'd4);
        check("bp_req_low", 32'(obs_req),   32'd0);
        check("bp_busy",    32'(obs_busy),  32'd1);
        check("bp_valid",   32'(obs_valid), 32'd1);
        ready_i = 1'b1;
        run_cycle();
        check("full_no_req", 32'(obs_req), 32'd0);
        ready_i = 1'b0;
        run_cycle();
        check("refill_req", 32'(obs_req), 32'd1);
        ready_i = 1'b1;
        run_cycle();
        check("pop_rvalid_no_req", 32'(obs_req),   32'd0);
        check("pop_rvalid_valid",  32'(obs_valid), 32'd1);
        drain("bp");

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset(32'h0000_0400);
        lat = 3; fetch_en_i = 1'b1; ready_i = 1'b1;
        repeat (3) run_cycle();
        check("rd2_two_out", 32'(n_req), 32'd2);
        redirect_addr_i = 32'h0000_1002;
        redirect_i      = 1'b1;
        run_cycle();
        redirect_i = 1'b0;
        run_cycle();
        check("rd2_valid_low", 32'(obs_valid), 32'd0);
        repeat (8) run_cycle();
        check("rd2_refetched", 32'(n_pop != 0), 32'd1);
        drain("rd2");

        // Redirect latency and redirect plus pop, 1-cycle memory.
        do_reset(32'h0000_3000);
        lat = 1; fetch_en_i = 1'b1; ready_i = 1'b1;
        repeat (6) run_cycle();
        redirect_addr_i = 32'h0000_2000;
        redirect_i      = 1'b1;
        run_cycle();
        check("rd_pop_valid", 32'(obs_valid), 32'd1);
        redirect_i = 1'b0;
        run_cycle();
        check("rd_r1_valid", 32'(obs_valid), 32'd0);
        check("rd_r1_req",   32'(obs_req),   32'd1);
        check("rd_r1_addr",  obs_addr,       32'h0000_2000);
        run_cycle();
        check("rd_r2_valid", 32'(obs_valid), 32'd0);
        run_cycle();
        check("rd_r3_valid", 32'(obs_valid), 32'd1);
        check("rd_r3_pc",    obs_pc,         32'h0000_2000);
        drain("rd");

        // Address wrap, then reset mid-stream and a spurious response.
        do_reset(32'hFFFF_FFFA);
        lat = 1; fetch_en_i = 1'b1; ready_i = 1'b1;
        run_cycle();
        run_cycle();
        check("wrap_a0", obs_addr, 32'hFFFF_FFF8);
        run_cycle();
        check("wrap_a1", obs_addr, 32'hFFFF_FFFC);
        run_cycle();
        check("wrap_a2", obs_addr, 32'h0000_0000);
        repeat (3) run_cycle();
        #1;
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("midrst");
        do_reset(32'h0000_0500);
        fetch_en_i = 1'b1; ready_i = 1'b1;
        run_cycle();
        spurious = 1'b1;
        run_cycle();
        check("spur_req", 32'(obs_req), 32'd1);
        repeat (4) run_cycle();
        drain("spur");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
